adder_result_accumulator: RTL

//  Downstream stage of the 4-bit adder with overflow.
//  - Consumes one {overflow, sum} result per valid/ready handshake.
//  - Accumulates FRAME_LEN results into a wider saturating register.
//  - Counts how many results carried overflow.
//  - Presents the frame total on a valid/ready output held until taken.

---
 rtl/adder_pkg.sv | 24 ++
 rtl/sat_add.sv | 26 ++
 rtl/adder_result_accumulator.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
//  Shared definitions for the adder result accumulator:
//   - default widths and frame length used as parameter defaults
//   - SAMPLE_W: width of one {overflow, sum} result from the 4-bit adder
//   - FSM state encoding of the accumulator
// ---------------------------------------------------------------------------
package adder_pkg;

    localparam int DATA_W_DEF    = 4;
    localparam int SAMPLE_W      = DATA_W_DEF + 1;
    // Default accumulator is twice the sample width: comfortably holds a
    // frame of eight full-scale samples without clipping.
    localparam int ACC_W_DEF     = 2 * SAMPLE_W;
    localparam int FRAME_LEN_DEF = 8;
    localparam int CNT_W_DEF     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sat_add.sv
// ---------------------------------------------------------------------------
// sat_add
//  Combinational saturating adder: o_sum = min(i_a + i_b, 2**ACC_W-1).
//  Ports:
//   i_a, i_b  in   ACC_W  operands (unsigned)
//   o_sum     out  ACC_W  clipped sum
//   o_sat     out  1      sum exceeded the representable maximum
// ---------------------------------------------------------------------------
module sat_add #(
    parameter int ACC_W = 10
) (
    input  logic [ACC_W-1:0] i_a,
    input  logic [ACC_W-1:0] i_b,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_sat
);

    logic [ACC_W:0] w_full;

    // One extra bit catches the carry; a carry means the true sum is
    // above 2**ACC_W-1, so the result is pinned to all ones.
    assign w_full = {1'b0, i_a} + {1'b0, i_b};
    assign o_sat  = w_full[ACC_W];
    assign o_sum  = o_sat ? '1 : w_full[ACC_W-1:0];

endmodule

// File: rtl/adder_result_accumulator.sv
// ---------------------------------------------------------------------------
// adder_result_accumulator
//  Downstream stage of the 4-bit adder with overflow. Sums FRAME_LEN
//  {overflow, sum} results into a saturating accumulator, counts results
//  that carried overflow, and offers the frame total on a valid/ready
//  output that is held until the consumer takes it.
//  Ports:
//   clk            in   1       clock, all state on rising edge
//   rst_n          in   1       asynchronous active-low reset
//   clear          in   1       synchronous abort, highest priority
//   in_valid       in   1       in_sum/in_overflow valid
//   in_ready       out  1       stage can accept a result
//   in_sum         in   DATA_W  adder sum
//   in_overflow    in   1       adder carry-out
//   out_valid      out  1       frame result available
//   out_ready      in   1       consumer takes the result
//   out_acc        out  ACC_W   frame total (saturated)
//   out_sat        out  1       total clipped at 2**ACC_W-1
//   out_ovf_count  out  CNT_W   results with in_overflow=1 (saturating)
//   busy           out  1       state != IDLE
// ---------------------------------------------------------------------------
module adder_result_accumulator
    import adder_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sum,
    input  logic              in_overflow,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_sat,
    output logic [CNT_W-1:0]  out_ovf_count,
    output logic              busy
);

    state_t             r_state;
    state_t             w_state_next;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_acc_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [CNT_W-1:0]   r_ovf_count;
    logic [CNT_W-1:0]   w_ovf_count_next;
    logic               r_sat;
    logic               w_sat_next;

    logic               w_can_accept;
    logic               w_accept;
    logic [ACC_W-1:0]   w_sample;
    logic [ACC_W-1:0]   w_add_sum;
    logic               w_add_sat;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [CNT_W-1:0]   w_ovf_step;

    // The overflow bit sits directly above the sum, so the sample is the
    // adder's full (DATA_W+1)-bit result, zero-extended.
    assign w_sample     = ACC_W'({in_overflow, in_sum});
    assign w_can_accept = (r_state != ST_DONE);
    assign w_accept     = in_valid & w_can_accept;
    assign w_cnt_inc    = r_cnt + CNT_W'(1);
    // Overflow count holds at all ones instead of wrapping.
    assign w_ovf_step   = (in_overflow && (r_ovf_count != '1))
                          ? r_ovf_count + CNT_W'(1) : r_ovf_count;

    sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .i_a   (r_acc),
        .i_b   (w_sample),
        .o_sum (w_add_sum),
        .o_sat (w_add_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf_count <= '0;
            r_sat       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_acc       <= w_acc_next;
            r_cnt       <= w_cnt_next;
            r_ovf_count <= w_ovf_count_next;
            r_sat       <= w_sat_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_acc_next       = r_acc;
        w_cnt_next       = r_cnt;
        w_ovf_count_next = r_ovf_count;
        w_sat_next       = r_sat;

        if (clear) begin
            // Abort wins over any concurrent accept or output handoff.
            w_state_next     = ST_IDLE;
            w_acc_next       = '0;
            w_cnt_next       = '0;
            w_ovf_count_next = '0;
            w_sat_next       = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        // First result of a frame overwrites the previous
                        // (already delivered) total rather than adding to it.
                        w_acc_next       = w_sample;
                        w_cnt_next       = CNT_W'(1);
                        w_ovf_count_next = CNT_W'(in_overflow);
                        w_sat_next       = 1'b0;
                        w_state_next     = (FRAME_LEN == 1) ? ST_DONE : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (w_accept) begin
                        w_acc_next       = w_add_sum;
                        w_sat_next       = r_sat | w_add_sat;
                        w_cnt_next       = w_cnt_inc;
                        w_ovf_count_next = w_ovf_step;
                        if (w_cnt_inc == CNT_W'(FRAME_LEN)) begin
                            w_state_next = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // All outputs come straight from state registers. in_ready is also
    // held low while reset is asserted so nothing upstream sees a
    // ready stage before the reset is released.
    assign in_ready      = rst_n & w_can_accept;
    assign out_valid     = (r_state == ST_DONE);
    assign busy          = (r_state != ST_IDLE);
    assign out_acc       = r_acc;
    assign out_sat       = r_sat;
    assign out_ovf_count = r_ovf_count;

endmodule
